// File: rtl/range_allocator.sv
// range_allocator: contiguous-range slot allocator.
//
// Manages NUM_SLOTS slots of GRAN bytes starting at address BASE. It serves
// variable-length, aligned first-fit allocations over a valid/ready request
// and response pair. A whole range is freed by presenting its head address.
//
// Ports:
//   clock, reset            rising-edge clock; synchronous active-high reset
//   alloc_valid/alloc_ready allocation request handshake (ready only in IDLE)
//   alloc_len, alloc_align  span in slots; log2 of the alignment in slots
//   rsp_valid/rsp_ready     response handshake
//   rsp_addr, rsp_fail      head address (0 on failure); failure flag
//   free_valid, free_addr   free request, always accepted
//   free_err                one-cycle pulse the cycle after an illegal free
//   used_count              number of slots currently allocated
//
// Optional build macro RANGE_ALLOC_HWM_EN adds:
//   hwm                     high-water mark of used_count since reset
//   hwm_clear               loads hwm with the current used_count
module range_allocator #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE      = 1,
  parameter int                GRAN      = 1,
  parameter int                NUM_SLOTS = 16,
  parameter int                MAX_SPAN  = 4,
  parameter int                LEN_W     = $clog2(MAX_SPAN + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [LEN_W-1:0]               alloc_len,
  input  logic [3:0]                     alloc_align,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ADDR_W-1:0]              rsp_addr,
  output logic                           rsp_fail,
  input  logic                           free_valid,
  input  logic [ADDR_W-1:0]              free_addr,
  output logic                           free_err,
`ifdef RANGE_ALLOC_HWM_EN
  output logic [$clog2(NUM_SLOTS+1)-1:0] hwm,
  input  logic                           hwm_clear,
`endif
  output logic [$clog2(NUM_SLOTS+1)-1:0] used_count
);

  localparam int          CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int          IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int          CW    = IDX_W + 1;
  localparam int          GSH   = $clog2(GRAN);
  localparam int unsigned NUM_U = NUM_SLOTS;
  localparam int unsigned MAX_U = MAX_SPAN;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [3:0]            align_q, align_d;
  logic [CW-1:0]         cand_q, cand_d;
  logic [NUM_SLOTS-1:0]  used_q, used_d;
  logic [NUM_SLOTS-1:0]  head_q, head_d;
  logic [LEN_W-1:0]      span_q [NUM_SLOTS];
  logic [LEN_W-1:0]      span_d [NUM_SLOTS];
  logic [ADDR_W-1:0]     rsp_addr_q, rsp_addr_d;
  logic                  rsp_fail_q, rsp_fail_d;
  logic                  free_err_q, free_err_d;
  logic [CNT_W-1:0]      used_count_q, used_count_d;

  // Search arithmetic is done at 32 bits so candidate + step never wraps.
  logic [31:0] cand_w, len_w, step_w, next_w;
  logic        req_bad, conflict, fit;

  assign cand_w  = 32'(cand_q);
  assign len_w   = 32'(len_q);
  assign step_w  = 32'd1 << align_q;
  assign next_w  = cand_w + step_w;
  assign req_bad = (len_q == '0) || (len_w > MAX_U) || (step_w > NUM_U);

  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < NUM_U; i++) begin
      if (i >= cand_w && i < cand_w + len_w && used_q[i]) conflict = 1'b1;
    end
  end

  assign fit = (cand_w + len_w <= NUM_U) && !conflict;

  // Free decode: byte offset from BASE -> slot index, legality check.
  logic [ADDR_W-1:0] free_off, free_idx_full;
  logic [IDX_W-1:0]  free_idx;
  logic [31:0]       free_idx_w, free_span_w;
  logic              free_legal;

  assign free_off      = free_addr - BASE;
  assign free_idx_full = free_off >> GSH;
  assign free_idx      = free_idx_full[IDX_W-1:0];
  assign free_idx_w    = 32'(free_idx);
  assign free_span_w   = 32'(span_q[free_idx]);
  assign free_legal    = free_valid && (free_addr >= BASE)
                         && ((free_off & ADDR_W'(GRAN - 1)) == '0)
                         && (free_idx_full < ADDR_W'(NUM_SLOTS))
                         && head_q[free_idx];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    align_d    = align_q;
    cand_d     = cand_q;
    used_d     = used_q;
    head_d     = head_q;
    span_d     = span_q;
    rsp_addr_d = rsp_addr_q;
    rsp_fail_d = rsp_fail_q;
    free_err_d = free_valid && !free_legal;

    // A free touches only allocated slots, a SEARCH mark only unallocated
    // ones, so both may be applied in the same cycle.
    if (free_legal) begin
      head_d[free_idx] = 1'b0;
      for (int unsigned i = 0; i < NUM_U; i++) begin
        if (i >= free_idx_w && i < free_idx_w + free_span_w) used_d[i] = 1'b0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (alloc_valid) begin
          len_d   = alloc_len;
          align_d = alloc_align;
          cand_d  = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (req_bad) begin
          rsp_addr_d = '0;
          rsp_fail_d = 1'b1;
          state_d    = S_RESP;
        end else if (fit) begin
          for (int unsigned i = 0; i < NUM_U; i++) begin
            if (i >= cand_w && i < cand_w + len_w) used_d[i] = 1'b1;
          end
          head_d[cand_q[IDX_W-1:0]] = 1'b1;
          span_d[cand_q[IDX_W-1:0]] = len_q;
          rsp_addr_d = BASE + (ADDR_W'(cand_q) << GSH);
          rsp_fail_d = 1'b0;
          state_d    = S_RESP;
        end else if (next_w + len_w > NUM_U) begin
          rsp_addr_d = '0;
          rsp_fail_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          cand_d = CW'(next_w);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_addr_d = '0;
          rsp_fail_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Popcount of the post-edge bitmap so alloc and free in one edge net out.
  always_comb begin
    used_count_d = '0;
    for (int unsigned i = 0; i < NUM_U; i++) begin
      used_count_d = used_count_d + CNT_W'(used_d[i]);
    end
  end

  // ---- state registers ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      used_q       <= '0;
      head_q       <= '0;
      rsp_addr_q   <= '0;
      rsp_fail_q   <= 1'b0;
      free_err_q   <= 1'b0;
      used_count_q <= '0;
    end else begin
      state_q      <= state_d;
      used_q       <= used_d;
      head_q       <= head_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_fail_q   <= rsp_fail_d;
      free_err_q   <= free_err_d;
      used_count_q <= used_count_d;
    end
  end

  // Request fields and span table are qualified by the FSM / head bitmap.
  always_ff @(posedge clock) begin
    len_q   <= len_d;
    align_q <= align_d;
    cand_q  <= cand_d;
    span_q  <= span_d;
  end

`ifdef RANGE_ALLOC_HWM_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clear)                  hwm_d = used_count_q;
    else if (used_count_q > hwm_q)  hwm_d = used_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

  assign alloc_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_addr    = rsp_addr_q;
  assign rsp_fail    = rsp_fail_q;
  assign free_err    = free_err_q;
  assign used_count  = used_count_q;

endmodule

// File: doc/range_allocator.md
Name: range_allocator

Overview:
- Hardware contiguous-range address allocator; RTL successor to the single-slot DPI allocator used by the simulation memory model.
- Manages NUM_SLOTS slots of GRAN bytes starting at BASE.
- Serves variable-length (1..MAX_SPAN slot) aligned allocation requests over a valid/ready request/response pair, and frees a whole range by its head address.
- Sits between DMA/descriptor engines and a memory region, so tests no longer depend on the software allocator.

Parameters:
- ADDR_W, 64: address width.
- BASE, 1: address of slot 0.
- GRAN, 1: bytes per slot; power of two.
- NUM_SLOTS, 16: slots managed; 2..1024.
- MAX_SPAN, 4: largest allocation, in slots; 1..NUM_SLOTS.
- LEN_W, $clog2(MAX_SPAN+1): width of alloc_len.

Ports:
- clock, input, 1: sole clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- alloc_valid, input, 1: allocation request valid.
- alloc_ready, output, 1: high only in IDLE.
- alloc_len, input, LEN_W: requested span in slots.
- alloc_align, input, 4: log2 of required alignment, in slots.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: response accepted.
- rsp_addr, output, ADDR_W: BASE + head_idx*GRAN; 0 on failure.
- rsp_fail, output, 1: no fit or illegal request.
- free_valid, input, 1: free request (free_ready is implicitly always 1).
- free_addr, input, ADDR_W: head address of the range to free.
- free_err, output, 1: one-cycle pulse, cycle after an illegal free.
- used_count, output, $clog2(NUM_SLOTS+1): slots currently allocated.

Behaviour:
- State: used bitmap[NUM_SLOTS], head bitmap[NUM_SLOTS], span table (LEN_W per slot).
- FSM IDLE -> SEARCH -> RESP -> IDLE.
- IDLE:
  - alloc_ready=1.
  - alloc_valid accepted at the edge; latches len and step = 1<<alloc_align; cand=0.
- SEARCH: one candidate per cycle.
  - len==0, len>MAX_SPAN, or step>NUM_SLOTS: go to RESP with fail, no bitmap change.
  - cand+len<=NUM_SLOTS and used[cand +: len] all 0: set those bits, set head[cand], span[cand]=len; go to RESP with addr.
  - Otherwise cand+=step; if cand+len>NUM_SLOTS, go to RESP with fail.
- Lowest-index fit always wins (first-fit).
- Latency: rsp_valid rises the cycle after the deciding SEARCH cycle. Candidate k decides in SEARCH cycle k+1 after accept, so rsp_valid rises k+2 cycles after accept.
- RESP: rsp_valid/rsp_addr/rsp_fail held stable until rsp_ready; return to IDLE on the edge where rsp_valid&rsp_ready. Next request accepted one cycle later at the earliest.
- Free:
  - Processed in any FSM state; takes effect at the edge.
  - Legal only if free_addr>=BASE, (free_addr-BASE)%GRAN==0, idx<NUM_SLOTS, and head[idx]==1.
  - Legal free clears used[idx +: span[idx]] and head[idx].
  - Illegal free: no state change; free_err=1 next cycle.
- Simultaneous free and SEARCH mark: both apply at the same edge (slot sets are disjoint).
- SEARCH reads the registered bitmap, so slots freed this edge become visible to the next candidate check.
- used_count: registered; equals the bitmap popcount after each edge; alloc and free in the same edge net correctly.
- Reset:
  - All bitmaps cleared, used_count=0, FSM=IDLE.
  - alloc_ready=0 during reset, 1 the cycle after.
  - rsp_valid=0, rsp_fail=0, rsp_addr=0, free_err=0.
  - Reset during SEARCH/RESP drops the request; no response is issued.

Optional Feature:
- RANGE_ALLOC_HWM_EN defined:
  - Adds output hwm (same width as used_count): registered maximum of used_count since reset; updates the cycle after used_count rises.
  - Adds input hwm_clear: synchronous; loads hwm with the current used_count.
- Undefined: both ports and all related logic absent; all other behaviour identical.

Test Plan:
1. Defaults; 8 requests len=1 align=0, rsp_ready=1 -> addrs 0x1..0x8, rsp_fail=0, used_count=8; first response 2 cycles after accept.
2. Free 0x1..0x8 one per cycle -> free_err never set, used_count=0; free 0x3 again -> free_err pulse, used_count unchanged.
3. Alloc len=1 (0x1), then len=4 align=2 -> 0x5 (slot 4), first-fit skips slot 0; free 0x6 -> free_err; free 0x5 -> used_count drops by 4.
4. Fill all 16 slots with len=4 (0x1,0x5,0x9,0xD), then len=1 -> rsp_fail=1, rsp_addr=0; also len=0 and len=5 -> rsp_fail=1.
5. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_addr stable, alloc_ready=0; assert reset mid-SEARCH -> no response, used_count=0, alloc_ready=1 after reset.
6. With RANGE_ALLOC_HWM_EN: alloc 6 slots, free 4 -> hwm=6, used_count=2; hwm_clear -> hwm=2.
